// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-state encoding, AXI read constants and NOP word
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_BUF  = 2'd3
  } fetch_state_e;

  localparam logic [3:0]  AXI_LEN_SINGLE = 4'd0;
  localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module ifid_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;

  // Bubble wins over load; with neither asserted the slot holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'd0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      pc_q    <= pc_i;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_axi.sv
// rtl/if_fetch_axi.sv - instruction fetch stage: one AXI4 single-beat read per PC,
// PC stall generation and IF/ID register update
module if_fetch_axi #(
  parameter int          ID_W     = 4,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     pc_in,
  input  logic            flush_ex,
  input  logic            hold_id,
  input  logic            dm_stall,
  output logic            pc_stall,
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [3:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY,
  output logic [31:0]     ifid_pc,
  output logic [31:0]     ifid_inst,
  output logic            ifid_valid,
  output logic            fetch_err
);

  import cpu_pkg::*;

  fetch_state_e state_q;
  logic         arvalid_q;
  logic         rready_q;
  logic [31:0]  buf_data_q;
  logic [1:0]   buf_resp_q;
  logic         fetch_err_q;

  logic         complete;
  logic [31:0]  cpl_data;
  logic [1:0]   cpl_resp;
  logic         cpl_err;
  logic         ifid_load;
  logic         ifid_bubble;
  logic         unused_rid;

  assign unused_rid = ^RID;

  // A fetch completes either straight off the last R beat or from the buffer
  // once the data-memory stall clears.
  always_comb begin
    complete = 1'b0;
    case (state_q)
      S_R:     complete = RVALID & RLAST & ~dm_stall;
      S_BUF:   complete = ~dm_stall;
      default: complete = 1'b0;
    endcase
  end

  assign cpl_data = (state_q == S_BUF) ? buf_data_q : RDATA;
  assign cpl_resp = (state_q == S_BUF) ? buf_resp_q : RRESP;
  assign cpl_err  = (cpl_resp != AXI_RESP_OKAY);

  // Error responses reuse the bubble path: NOP with the slot marked invalid.
  assign ifid_bubble = complete & (flush_ex | (~hold_id & cpl_err));
  assign ifid_load   = complete & ~flush_ex & ~hold_id & ~cpl_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      buf_data_q  <= 32'd0;
      buf_resp_q  <= AXI_RESP_OKAY;
      fetch_err_q <= 1'b0;
    end else begin
      if (complete && !flush_ex && !hold_id && cpl_err) begin
        fetch_err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          state_q   <= S_AR;
          arvalid_q <= 1'b1;
        end
        S_AR: begin
          if (ARREADY) begin
            state_q   <= S_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_R: begin
          if (RVALID && RLAST) begin
            rready_q <= 1'b0;
            if (dm_stall) begin
              buf_data_q <= RDATA;
              buf_resp_q <= RRESP;
              state_q    <= S_BUF;
            end else begin
              state_q   <= S_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_BUF: begin
          if (!dm_stall) begin
            state_q   <= S_AR;
            arvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .pc_i     (pc_in),
    .inst_i   (cpl_data),
    .pc_o     (ifid_pc),
    .inst_o   (ifid_inst),
    .valid_o  (ifid_valid)
  );

  assign pc_stall  = ~complete;
  assign ARID      = '0;
  assign ARADDR    = pc_in;
  assign ARLEN     = AXI_LEN_SINGLE;
  assign ARSIZE    = AXI_SIZE_WORD;
  assign ARBURST   = AXI_BURST_INCR;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign fetch_err = fetch_err_q;

endmodule
